level_unpacker: RTL and testbench

LEVEL_UNPACKER -- requirements
Module: level_unpacker

---
 rtl/level_unpacker_pkg.sv | 18 +
 rtl/level_fifo.sv | 48 ++++
 rtl/level_unpacker.sv | 136 +++++++++++++
 tb/tb_level_unpacker.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/level_unpacker_pkg.sv
// Shared definitions for the level unpacker: default widths, FSM state codes
// and the per-word side-band tag stored alongside each buffered word.
package level_unpacker_pkg;

    localparam int LEVEL_W_DEF  = 16;
    localparam int PIPE_LAT_DEF = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LANE0 = 2'd1;
    localparam logic [1:0] ST_LANE1 = 2'd2;

    typedef struct packed {
        logic last;
        logic is_weight;
        logic single;
    } word_tag_t;

endpackage

// File: rtl/level_fifo.sv
// Synchronous FIFO with wrap-bit pointers; exposes occupancy so the consumer
// can look one pop ahead.
module level_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define
    // which entries are valid, and a resettable array costs real flops.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/level_unpacker.sv
// Splits buffered two-level words into one sign-extended level per cycle and
// tracks valid/last through the downstream dequantizer latency.
module level_unpacker
    import level_unpacker_pkg::*;
#(
    parameter int LEVEL_W    = LEVEL_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int PIPE_LAT   = PIPE_LAT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*LEVEL_W-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_single,
    input  logic                   in_is_weight,
    input  logic                   in_last,
    output logic [31:0]            level_int,
    output logic                   is_weight,
    output logic                   res_valid,
    output logic                   res_last,
    output logic [15:0]            level_count
);

    localparam int DW = 2*LEVEL_W;
    localparam int EW = DW + $bits(word_tag_t);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            push, pop, full, empty;
    logic [CW-1:0]   count;
    logic [EW-1:0]   head_word;
    word_tag_t       in_tag, head_tag;
    logic [DW-1:0]   head_data;

    logic [1:0]          state, state_nxt;
    logic                emit, last_now, more;
    logic [LEVEL_W-1:0]  lane;
    logic                emit_valid, emit_last;
    logic [PIPE_LAT-1:0] vld_pipe, last_pipe;

    assign in_tag   = '{last: in_last, is_weight: in_is_weight, single: in_single};
    assign in_ready = rst && !full;
    assign push     = in_valid && in_ready;

    level_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({in_tag, in_data}),
        .pop       (pop),
        .head      (head_word),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign head_tag  = word_tag_t'(head_word[EW-1:DW]);
    assign head_data = head_word[DW-1:0];

    // A word written this cycle becomes the head right after the pop, so the
    // FSM can chain straight into it without a bubble.
    assign more = (count > CW'(1)) || push;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        emit      = 1'b0;
        last_now  = 1'b0;
        lane      = head_data[LEVEL_W-1:0];
        case (state)
            ST_IDLE: begin
                if (!empty) state_nxt = ST_LANE0;
            end
            ST_LANE0: begin
                emit = 1'b1;
                if (head_tag.single) begin
                    pop       = 1'b1;
                    last_now  = head_tag.last;
                    state_nxt = more ? ST_LANE0 : ST_IDLE;
                end else begin
                    state_nxt = ST_LANE1;
                end
            end
            ST_LANE1: begin
                emit      = 1'b1;
                lane      = head_data[DW-1:LEVEL_W];
                pop       = 1'b1;
                last_now  = head_tag.last;
                state_nxt = more ? ST_LANE0 : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            emit_valid  <= 1'b0;
            emit_last   <= 1'b0;
            level_int   <= '0;
            is_weight   <= 1'b0;
            level_count <= '0;
        end else begin
            state      <= state_nxt;
            emit_valid <= emit;
            emit_last  <= last_now;
            level_int  <= emit ? 32'($signed(lane)) : 32'd0;
            is_weight  <= emit && head_tag.is_weight;
            // A level emitted right after a tensor end is the first of the next one.
            if (emit_last)
                level_count <= emit ? 16'd1 : 16'd0;
            else if (emit && level_count != 16'hFFFF)
                level_count <= level_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[0]  <= emit_valid;
            last_pipe[0] <= emit_last;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    assign res_valid = vld_pipe[PIPE_LAT-1];
    assign res_last  = last_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_level_unpacker.sv
// Scoreboard bench for level_unpacker: expected levels are queued on word
// acceptance and matched against level_int as it stood PIPE_LAT cycles before res_valid.
module tb_level_unpacker;

    localparam int LEVEL_W  = 16;
    localparam int PIPE_LAT = 5;

    typedef struct {
        logic [31:0] level;
        logic        w;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0, in_single = 1'b0, in_is_weight = 1'b0, in_last = 1'b0;
    logic        in_ready;
    logic [31:0] level_int;
    logic        is_weight, res_valid, res_last;
    logic [15:0] level_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_res    = 0;
    int   stalls   = 0;
    int   run_len  = 0;
    int   max_run  = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [31:0] lvl_hist [PIPE_LAT+1];
    logic        w_hist   [PIPE_LAT+1];

    level_unpacker #(.LEVEL_W(LEVEL_W), .FIFO_DEPTH(4), .PIPE_LAT(PIPE_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_single    (in_single),
        .in_is_weight (in_is_weight),
        .in_last      (in_last),
        .level_int    (level_int),
        .is_weight    (is_weight),
        .res_valid    (res_valid),
        .res_last     (res_last),
        .level_count  (level_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Called just after a clock edge; returns just after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic single, input logic w,
                             input logic last);
        int waited = 0;
        in_data = d; in_single = single; in_is_weight = w; in_last = last;
        in_valid = 1'b1;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
            stalls++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back('{level: sext(d[15:0]), w: w, last: last && single});
        if (!single) sb.push_back('{level: sext(d[31:16]), w: w, last: last});
    endtask

    task automatic drain(input string tag);
        int waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        repeat (PIPE_LAT + 2) @(negedge clk);
        check({tag, "_drain"}, sb.size(), 0);
        check({tag, "_idle_level"}, level_int, 32'd0);
        check({tag, "_idle_weight"}, {31'd0, is_weight}, 32'd0);
        check({tag, "_idle_count"}, {16'd0, level_count}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            run_len = 0;
        end else begin
            for (int i = PIPE_LAT; i > 0; i--) begin
                lvl_hist[i] = lvl_hist[i-1];
                w_hist[i]   = w_hist[i-1];
            end
            lvl_hist[0] = level_int;
            w_hist[0]   = is_weight;
            if (res_valid) begin
                n_res++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (sb.size() == 0) begin
                    check("spurious_res_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("level", lvl_hist[PIPE_LAT], mon_e.level);
                    check("is_weight", {31'd0, w_hist[PIPE_LAT]}, {31'd0, mon_e.w});
                    check("res_last", {31'd0, res_last}, {31'd0, mon_e.last});
                end
            end else begin
                run_len = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int res_before;
        int stalls_before;
        logic [31:0] rw;

        // Reset state
        #3;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_level", level_int, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_last", {31'd0, res_last}, 32'd0);
        check("rst_count", {16'd0, level_count}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Two-lane weights: 14562 then 4096, last on lane 1
        send_word(32'h1000_38E2, 1'b0, 1'b1, 1'b1);
        drain("basic");

        // Negative levels in both lanes
        send_word(32'hC000_FFFF, 1'b0, 1'b1, 1'b0);
        send_word(32'h7FFF_8000, 1'b0, 1'b0, 1'b1);
        drain("neg");

        // Single-lane activation; level_count 1 then 0
        @(posedge clk); #1;
        send_word(32'hDEAD_0001, 1'b1, 1'b0, 1'b1);
        waited = 0;
        @(negedge clk);
        while (level_int != 32'd1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("single_seen", level_int, 32'd1);
        check("single_count_1", {16'd0, level_count}, 32'd1);
        @(negedge clk);
        check("single_count_0", {16'd0, level_count}, 32'd0);
        drain("single");

        // Mixed single/dual words with random data
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            rw = $urandom;
            send_word(rw, 1'(i % 3 == 1), 1'(i % 2), 1'(i == 7));
        end
        drain("mixed");

        // Back-to-back burst of 10 words
        @(posedge clk); #1;
        max_run = 0;
        stalls_before = stalls;
        for (int i = 0; i < 10; i++)
            send_word(32'h0100_0000 * i + 32'(i * 3 + 1), 1'b0, 1'b1, 1'(i == 9));
        drain("burst");
        check("burst_stalled", {31'd0, 1'(stalls > stalls_before)}, 32'd1);
        check("burst_no_bubble", max_run, 20);

        // Reset after 3 of 6 words
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
            send_word(32'h0020_0010 + 32'(i), 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        sb.delete();
        #1;
        check("midrst_level", level_int, 32'd0);
        check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_count", {16'd0, level_count}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        res_before = n_res;
        repeat (15) @(negedge clk);
        check("midrst_no_res", n_res - res_before, 0);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++)
            send_word(32'h0020_0010 + 32'(i), 1'b0, 1'b0, 1'(i == 5));
        drain("resend");

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
